redirect_ctrl: RTL

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

---
 rtl/redirect_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: fetch-address sequencer with branch/jump redirect handling.
// Keeps PCF stable while an outstanding fetch request is not accepted. A
// redirect that arrives during a stalled fetch is parked in a target register
// until the instruction memory accepts the current request.
module redirect_ctrl #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcE,
    input  logic             BranchTakenE,
    input  logic             RVPCSrcE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [3:0]       FlagsD,
    input  logic             StallE,
    input  logic             FetchReady,
    output logic             FetchValid,
    output logic [WIDTH-1:0] PCF,
    output logic             FlushD,
    output logic             FlushE,
    output logic [3:0]       FlagsE,
    output logic             Pending
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] target_next;
    logic [3:0]       flags_reg;

    logic             redir;
    logic [WIDTH-1:0] target;
    logic             fetch_valid;
    logic             fetch_fire;
    logic             fetch_blocked;

    // A stalled execute stage cannot redirect: its control signals are not final.
    assign redir  = (PCSrcE | BranchTakenE | RVPCSrcE) & ~StallE;

    // Instruction fetch addresses are word aligned.
    assign target = {ALUResultE[WIDTH-1:2], 2'b00};

    // A request is always offered except while reset holds the front end.
    assign fetch_valid   = ~reset;
    assign fetch_fire    = fetch_valid & FetchReady;
    assign fetch_blocked = fetch_valid & ~FetchReady;

    // Next-state, next-PC and parked-target selection.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        unique case (state_reg)
            RUN: begin
                if (redir) begin
                    if (fetch_blocked) begin
                        // Current request must stay stable; park the target.
                        target_next = target;
                        state_next  = PEND;
                    end else begin
                        pc_next = target;
                    end
                end else if (fetch_fire) begin
                    // Natural wrap at the top of the address space is intended.
                    pc_next = pc_reg + WIDTH'(4);
                end
            end
            PEND: begin
                // The youngest redirect always replaces a parked one.
                if (redir) begin
                    target_next = target;
                end
                if (FetchReady) begin
                    pc_next    = redir ? target : target_reg;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // FSM, PC and parked-target registers; reset discards any parked target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
        end
    end

    // Condition flags advance with the execute stage, independent of flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else if (!StallE) begin
            flags_reg <= FlagsD;
        end
    end

    assign FetchValid = fetch_valid;
    assign PCF        = pc_reg;
    assign FlushE     = redir;
    // Decode holds a wrong-path instruction on a redirect and for as long as
    // the redirect is parked.
    assign FlushD     = redir | (state_reg == PEND);
    assign FlagsE     = flags_reg;
    assign Pending    = (state_reg == PEND);

endmodule
